axi2apb_bridge: RTL and testbench

- Slave-side protocol bridge placed directly downstream of the AXI interconnect's peripheral slave port, window 0x1A10_0000–0x1A11_FFFF.
- Converts 64-bit AXI4 read/write bursts into sequential 32-bit APB3 transfers, one APB access per AXI beat.
- Feeds the APB peripheral bus (UART, GPIO, SPI master).
- Handles one transaction at a time; reads and writes are arbitrated round-robin.

---
 rtl/axi2apb_bridge_if.sv | 72 +++++++
 rtl/axi2apb_bridge.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi2apb_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2apb_bridge_if.sv
// AXI4 slave-side bundle used by the AXI-to-APB bridge.
// User fields collapse to one bit when AXI_USER_WIDTH is 0.
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 2,
    parameter int AXI_USER_WIDTH = 0
);
    localparam int UW = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;

    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [UW-1:0]               b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [UW-1:0]               r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi2apb_bridge.sv
// AXI4 (64-bit) to APB3 (32-bit) bridge, one APB access per beat.
// Define AXI2APB_TIMEOUT_EN to bound the ACCESS phase by TIMEOUT_CYCLES.
module axi2apb_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 2,
    parameter int AXI_USER_WIDTH = 0,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    AXI_BUS.Slave                     slave,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [31:0]               pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [31:0]               prdata,
    input  logic                      pready,
    input  logic                      pslverr
);
    typedef enum logic [2:0] {
        IDLE, WDATA, SETUP, ACCESS, WRESP, RDATA
    } state_t;

    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;

    state_t                    r_state, w_state_nxt;
    logic [AXI_ID_WIDTH-1:0]   r_id, w_id_nxt;
    logic [AXI_ADDR_WIDTH-1:0] r_addr, w_addr_nxt, w_addr_adv;
    logic [7:0]                r_cnt, w_cnt_nxt;
    logic [2:0]                r_size, w_size_nxt;
    logic [1:0]                r_burst, w_burst_nxt;
    logic                      r_write, w_write_nxt;
    logic [31:0]               r_pwdata, w_pwdata_nxt;
    logic [31:0]               r_rdata, w_rdata_nxt;
    logic [1:0]                r_rresp, w_rresp_nxt;
    logic                      r_err, w_err_nxt;
    logic                      r_ptr_w, w_ptr_w_nxt;
    logic                      w_grant_w, w_grant_r;
    logic                      w_aw_ready, w_ar_ready, w_w_ready;
    logic                      w_done, w_slverr;
    logic [31:0]               w_prd;
    logic                      w_unused;

`ifdef AXI2APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          w_tmo;

    always_ff @(posedge clk) begin
        if (!rst_n || r_state == SETUP)
            r_tmo <= '0;
        else if (r_state == ACCESS && !pready)
            r_tmo <= r_tmo + 1'b1;
    end

    // Last waiting cycle of a hung access completes it as an error.
    assign w_tmo    = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_done   = pready || w_tmo;
    assign w_slverr = pready ? pslverr : 1'b1;
    assign w_prd    = pready ? prdata : 32'hDEAD_BEEF;
`else
    assign w_done   = pready;
    assign w_slverr = pslverr;
    assign w_prd    = prdata;
`endif

    assign w_unused = ^{slave.w_strb, 32'(TIMEOUT_CYCLES),
                        32'(AXI_DATA_WIDTH), 32'(AXI_USER_WIDTH)};

    // WRAP bursts deliberately walk linearly like INCR.
    assign w_addr_adv = (r_burst == 2'b00) ? r_addr
                      : r_addr + (AXI_ADDR_WIDTH'(1) << r_size);

    assign w_grant_w = slave.aw_valid && (r_ptr_w || !slave.ar_valid);
    assign w_grant_r = slave.ar_valid && !w_grant_w;

    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_size_nxt   = r_size;
        w_burst_nxt  = r_burst;
        w_write_nxt  = r_write;
        w_pwdata_nxt = r_pwdata;
        w_rdata_nxt  = r_rdata;
        w_rresp_nxt  = r_rresp;
        w_err_nxt    = r_err;
        w_ptr_w_nxt  = r_ptr_w;
        w_aw_ready   = 1'b0;
        w_ar_ready   = 1'b0;
        w_w_ready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_aw_ready = w_grant_w;
                w_ar_ready = w_grant_r;
                if (w_grant_w) begin
                    w_id_nxt    = slave.aw_id;
                    w_addr_nxt  = slave.aw_addr;
                    w_cnt_nxt   = slave.aw_len;
                    w_size_nxt  = slave.aw_size;
                    w_burst_nxt = slave.aw_burst;
                    w_write_nxt = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_ptr_w_nxt = 1'b0;
                    w_state_nxt = WDATA;
                end else if (w_grant_r) begin
                    w_id_nxt    = slave.ar_id;
                    w_addr_nxt  = slave.ar_addr;
                    w_cnt_nxt   = slave.ar_len;
                    w_size_nxt  = slave.ar_size;
                    w_burst_nxt = slave.ar_burst;
                    w_write_nxt = 1'b0;
                    w_ptr_w_nxt = 1'b1;
                    if (slave.ar_size == 3'd3) begin
                        w_rdata_nxt = '0;
                        w_rresp_nxt = SLVERR;
                        w_state_nxt = RDATA;
                    end else begin
                        w_state_nxt = SETUP;
                    end
                end
            end
            WDATA: begin
                w_w_ready = 1'b1;
                if (slave.w_valid) begin
                    w_pwdata_nxt = r_addr[2] ? slave.w_data[63:32]
                                             : slave.w_data[31:0];
                    if (slave.w_last != (r_cnt == 8'd0))
                        w_err_nxt = 1'b1;
                    if (r_size == 3'd3) begin
                        w_err_nxt = 1'b1;
                        if (r_cnt == 8'd0) begin
                            w_state_nxt = WRESP;
                        end else begin
                            w_cnt_nxt  = r_cnt - 8'd1;
                            w_addr_nxt = w_addr_adv;
                        end
                    end else begin
                        w_state_nxt = SETUP;
                    end
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                if (w_done) begin
                    if (r_write) begin
                        w_err_nxt = r_err | w_slverr;
                        if (r_cnt == 8'd0) begin
                            w_state_nxt = WRESP;
                        end else begin
                            w_cnt_nxt   = r_cnt - 8'd1;
                            w_addr_nxt  = w_addr_adv;
                            w_state_nxt = WDATA;
                        end
                    end else begin
                        w_rdata_nxt = w_prd;
                        w_rresp_nxt = w_slverr ? SLVERR : OKAY;
                        w_state_nxt = RDATA;
                    end
                end
            end
            RDATA: begin
                if (slave.r_ready) begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt  = r_cnt - 8'd1;
                        w_addr_nxt = w_addr_adv;
                        if (r_size == 3'd3) begin
                            w_rdata_nxt = '0;
                            w_rresp_nxt = SLVERR;
                        end else begin
                            w_state_nxt = SETUP;
                        end
                    end
                end
            end
            WRESP: begin
                if (slave.b_ready) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_write  <= 1'b0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_err    <= 1'b0;
            r_ptr_w  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_id     <= w_id_nxt;
            r_addr   <= w_addr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_size   <= w_size_nxt;
            r_burst  <= w_burst_nxt;
            r_write  <= w_write_nxt;
            r_pwdata <= w_pwdata_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rresp  <= w_rresp_nxt;
            r_err    <= w_err_nxt;
            r_ptr_w  <= w_ptr_w_nxt;
        end
    end

    assign slave.aw_ready = w_aw_ready && rst_n;
    assign slave.ar_ready = w_ar_ready && rst_n;
    assign slave.w_ready  = w_w_ready && rst_n;

    assign slave.b_valid = (r_state == WRESP);
    assign slave.b_id    = r_id;
    assign slave.b_resp  = r_err ? SLVERR : OKAY;
    assign slave.b_user  = '0;

    assign slave.r_valid = (r_state == RDATA);
    assign slave.r_id    = r_id;
    assign slave.r_data  = {r_rdata, r_rdata};
    assign slave.r_resp  = r_rresp;
    assign slave.r_last  = (r_state == RDATA) && (r_cnt == 8'd0);
    assign slave.r_user  = '0;

    assign psel    = (r_state == SETUP) || (r_state == ACCESS);
    assign penable = (r_state == ACCESS);
    assign pwrite  = r_write;
    assign paddr   = {r_addr[APB_ADDR_WIDTH-1:2], 2'b00};
    assign pwdata  = r_pwdata;
endmodule

// File: tb/tb_axi2apb_bridge.sv
// Scoreboard bench for axi2apb_bridge: directed AXI traffic,
// queued expectations checked by APB/R/B/grant monitors.
module tb_axi2apb_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(2), .AXI_USER_WIDTH(0)
    ) bus ();

    logic [31:0] paddr, pwdata, prdata, err_addr;
    logic        pwrite, psel, penable, pready, pslverr;

    axi2apb_bridge dut (
        .clk(clk), .rst_n(rst_n), .slave(bus),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    // APB peripheral: one fixed word, otherwise {addr, ~addr} halves.
    assign prdata  = (paddr == 32'h1A10_0004) ? 32'h1234_5678
                   : {paddr[15:0], ~paddr[15:0]};
    assign pslverr = psel && penable && (paddr == err_addr);

    typedef struct {
        logic [31:0] a; logic w; logic [31:0] d;
    } apb_t;
    typedef struct {
        logic [63:0] d; logic [1:0] resp; logic last;
        logic [1:0] id; logic cd;
    } r_t;
    typedef struct { logic [1:0] resp; logic [1:0] id; } b_t;

    apb_t apb_q[$];
    r_t   r_q[$];
    b_t   b_q[$];
    byte  g_q[$];
    apb_t me;
    r_t   mr;
    b_t   mb;
    byte  mg;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event with empty queue at cycle %0d", nm, cyc);
    endtask

    task automatic exp_apb(input logic [31:0] a, input logic w,
                           input logic [31:0] d);
        apb_q.push_back('{a: a, w: w, d: d});
    endtask
    task automatic exp_r(input logic [63:0] d, input logic [1:0] rs,
                         input logic l, input logic [1:0] id,
                         input logic cd);
        r_q.push_back('{d: d, resp: rs, last: l, id: id, cd: cd});
    endtask
    task automatic exp_b(input logic [1:0] rs, input logic [1:0] id);
        b_q.push_back('{resp: rs, id: id});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (psel && penable && pready) begin
                if (apb_q.size() == 0) unexpected("apb_extra");
                else begin
                    me = apb_q.pop_front();
                    chk("paddr", {32'h0, paddr}, {32'h0, me.a});
                    chk("pwrite", {63'h0, pwrite}, {63'h0, me.w});
                    if (me.w) chk("pwdata", {32'h0, pwdata}, {32'h0, me.d});
                end
            end
            if (bus.r_valid && bus.r_ready) begin
                if (r_q.size() == 0) unexpected("r_extra");
                else begin
                    mr = r_q.pop_front();
                    if (mr.cd) chk("r_data", bus.r_data, mr.d);
                    chk("r_resp", {62'h0, bus.r_resp}, {62'h0, mr.resp});
                    chk("r_last", {63'h0, bus.r_last}, {63'h0, mr.last});
                    chk("r_id", {62'h0, bus.r_id}, {62'h0, mr.id});
                end
            end
            if (bus.b_valid && bus.b_ready) begin
                if (b_q.size() == 0) unexpected("b_extra");
                else begin
                    mb = b_q.pop_front();
                    chk("b_resp", {62'h0, bus.b_resp}, {62'h0, mb.resp});
                    chk("b_id", {62'h0, bus.b_id}, {62'h0, mb.id});
                end
            end
            if (g_q.size() != 0) begin
                mg = 8'h0;
                if (bus.aw_valid && bus.aw_ready) mg = "W";
                if (bus.ar_valid && bus.ar_ready) mg = "R";
                if (mg != 8'h0)
                    chk("grant", {56'h0, mg}, {56'h0, g_q.pop_front()});
            end
        end
    end

    function automatic bit hs(input int k);
        case (k)
            0: return bus.aw_valid && bus.aw_ready;
            1: return bus.w_valid && bus.w_ready;
            2: return bus.b_valid && bus.b_ready;
            3: return bus.ar_valid && bus.ar_ready;
            4: return bus.r_valid && bus.r_ready;
            5: return psel && penable;
            6: return bus.r_valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hs(input int k, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hs(k) && n < 400);
        checks++;
        if (!hs(k)) begin
            errors++;
            $display("FAIL %s: no event after %0d cycles, required one", nm, n);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [1:0] id,
                             input logic [7:0] len, input logic [63:0] d0,
                             input logic [63:0] d1, input bit early,
                             input bit lat);
        int t;
        bus.aw_addr = a; bus.aw_id = id; bus.aw_len = len;
        bus.aw_size = 3'd2; bus.aw_burst = 2'b01; bus.aw_valid = 1'b1;
        wait_hs(0, "aw_hs");
        t = cyc;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.w_data  = (i == 0) ? d0 : d1;
            bus.w_last  = early ? (i == 0) : (i == int'(len));
            bus.w_strb  = '1;
            bus.w_valid = 1'b1;
            wait_hs(1, "w_hs");
            @(posedge clk); #1;
            bus.w_valid = 1'b0;
        end
        wait_hs(2, "b_hs");
        if (lat) chk("b_latency", 64'(cyc - t), 64'd4);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [1:0] id,
                            input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bt, input bit lat,
                            input int stall, input logic [63:0] sd);
        int t;
        bus.ar_addr = a; bus.ar_id = id; bus.ar_len = len;
        bus.ar_size = sz; bus.ar_burst = bt; bus.ar_valid = 1'b1;
        wait_hs(3, "ar_hs");
        t = cyc;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall) begin
                bus.r_ready = 1'b0;
                wait_hs(6, "stall_rvalid");
                for (int j = 0; j < 5; j++) begin
                    chk("stall_psel", {63'h0, psel}, 64'h0);
                    chk("stall_rdata", bus.r_data, sd);
                    if (j < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                bus.r_ready = 1'b1;
            end
            wait_hs(4, "r_hs");
            if (i == 0 && lat) chk("r_latency", 64'(cyc - t), 64'd3);
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] bd [4] = '{32'h2000_DFFF, 32'h2004_DFFB,
                            32'h2008_DFF7, 32'h200C_DFF3};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.aw_valid = 1'b1; bus.ar_valid = 1'b1; bus.w_valid = 1'b0;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.aw_size = '0; bus.aw_burst = '0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.ar_size = '0; bus.ar_burst = '0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        pready = 1'b1; err_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_aw_ready", {63'h0, bus.aw_ready}, 64'h0);
        chk("rst_ar_ready", {63'h0, bus.ar_ready}, 64'h0);
        chk("rst_w_ready", {63'h0, bus.w_ready}, 64'h0);
        chk("rst_psel", {63'h0, psel}, 64'h0);
        chk("rst_penable", {63'h0, penable}, 64'h0);
        chk("rst_pwrite", {63'h0, pwrite}, 64'h0);
        chk("rst_paddr", {32'h0, paddr}, 64'h0);
        chk("rst_pwdata", {32'h0, pwdata}, 64'h0);
        chk("rst_r_valid", {63'h0, bus.r_valid}, 64'h0);
        chk("rst_b_valid", {63'h0, bus.b_valid}, 64'h0);
        chk("rst_r_data", bus.r_data, 64'h0);
        chk("rst_b_resp", {62'h0, bus.b_resp}, 64'h0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        exp_apb(32'h1A10_0004, 1'b0, 32'h0);
        exp_r(64'h1234_5678_1234_5678, 2'b00, 1'b1, 2'd2, 1'b1);
        axi_read(32'h1A10_0004, 2'd2, 8'd0, 3'd2, 2'b01, 1'b1, -1, 64'h0);

        exp_apb(32'h1A10_1000, 1'b1, 32'h5555_5555);
        exp_b(2'b00, 2'd1);
        axi_write(32'h1A10_1000, 2'd1, 8'd0, 64'hAAAA_AAAA_5555_5555,
                  64'h0, 1'b0, 1'b1);
        exp_apb(32'h1A10_1004, 1'b1, 32'hAAAA_AAAA);
        exp_b(2'b00, 2'd1);
        axi_write(32'h1A10_1004, 2'd1, 8'd0, 64'hAAAA_AAAA_5555_5555,
                  64'h0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            exp_apb(32'h1A10_2000 + 32'(4 * i), 1'b0, 32'h0);
            exp_r({bd[i], bd[i]}, 2'b00, (i == 3), 2'd3, 1'b1);
        end
        axi_read(32'h1A10_2000, 2'd3, 8'd3, 3'd2, 2'b01, 1'b0, 1,
                 {bd[1], bd[1]});

        err_addr = 32'h1A10_3000;
        exp_apb(32'h1A10_3000, 1'b1, 32'h2222_2222);
        exp_apb(32'h1A10_3004, 1'b1, 32'h3333_3333);
        exp_b(2'b10, 2'd0);
        axi_write(32'h1A10_3000, 2'd0, 8'd1, 64'h1111_1111_2222_2222,
                  64'h3333_3333_4444_4444, 1'b0, 1'b0);
        err_addr = 32'h0;
        exp_apb(32'h1A10_3008, 1'b1, 32'hCAFE_F00D);
        exp_b(2'b00, 2'd0);
        axi_write(32'h1A10_3008, 2'd0, 8'd0, 64'h0000_0000_CAFE_F00D,
                  64'h0, 1'b0, 1'b0);

        exp_apb(32'h1A10_4000, 1'b1, 32'h0000_0001);
        exp_apb(32'h1A10_4004, 1'b1, 32'h0000_0003);
        exp_b(2'b10, 2'd2);
        axi_write(32'h1A10_4000, 2'd2, 8'd1, 64'h1,
                  64'h0000_0003_0000_0000, 1'b1, 1'b0);

        for (int i = 0; i < 2; i++) begin
            exp_apb(32'h1A10_5000, 1'b0, 32'h0);
            exp_r(64'h5000_AFFF_5000_AFFF, 2'b00, (i == 1), 2'd1, 1'b1);
        end
        axi_read(32'h1A10_5000, 2'd1, 8'd1, 3'd2, 2'b00, 1'b0, -1, 64'h0);

        exp_r(64'h0, 2'b10, 1'b1, 2'd0, 1'b0);
        axi_read(32'h1A10_6000, 2'd0, 8'd0, 3'd3, 2'b01, 1'b0, -1, 64'h0);

        g_q.push_back("W"); g_q.push_back("R");
        g_q.push_back("W"); g_q.push_back("R");
        exp_apb(32'h1A10_7000, 1'b1, 32'h7777_0000);
        exp_apb(32'h1A10_7100, 1'b0, 32'h0);
        exp_apb(32'h1A10_7004, 1'b1, 32'h8888_0000);
        exp_apb(32'h1A10_7104, 1'b0, 32'h0);
        exp_b(2'b00, 2'd1); exp_b(2'b00, 2'd1);
        exp_r(64'h7100_8EFF_7100_8EFF, 2'b00, 1'b1, 2'd2, 1'b1);
        exp_r(64'h7104_8EFB_7104_8EFB, 2'b00, 1'b1, 2'd2, 1'b1);
        fork
            begin
                axi_write(32'h1A10_7000, 2'd1, 8'd0,
                          64'h0000_0000_7777_0000, 64'h0, 1'b0, 1'b0);
                axi_write(32'h1A10_7004, 2'd1, 8'd0,
                          64'h8888_0000_0000_0000, 64'h0, 1'b0, 1'b0);
            end
            begin
                axi_read(32'h1A10_7100, 2'd2, 8'd0, 3'd2, 2'b01,
                         1'b0, -1, 64'h0);
                axi_read(32'h1A10_7104, 2'd2, 8'd0, 3'd2, 2'b01,
                         1'b0, -1, 64'h0);
            end
        join

        pready = 1'b0;
        bus.ar_addr = 32'h1A10_8000; bus.ar_id = 2'd0; bus.ar_len = 8'd0;
        bus.ar_size = 3'd2; bus.ar_burst = 2'b01; bus.ar_valid = 1'b1;
        wait_hs(3, "rst_ar_hs");
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        wait_hs(5, "rst_access");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_rst_psel", {63'h0, psel}, 64'h1);
        @(negedge clk);
        chk("midrst_psel", {63'h0, psel}, 64'h0);
        chk("midrst_penable", {63'h0, penable}, 64'h0);
        chk("midrst_r_valid", {63'h0, bus.r_valid}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pready = 1'b1;
        @(posedge clk); #1;

        exp_apb(32'h1A10_0004, 1'b0, 32'h0);
        exp_r(64'h1234_5678_1234_5678, 2'b00, 1'b1, 2'd1, 1'b1);
        axi_read(32'h1A10_0004, 2'd1, 8'd0, 3'd2, 2'b01, 1'b1, -1, 64'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("apb_q_left", 64'(apb_q.size()), 64'h0);
        chk("r_q_left", 64'(r_q.size()), 64'h0);
        chk("b_q_left", 64'(b_q.size()), 64'h0);
        chk("g_q_left", 64'(g_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
